// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-enable divider, h/v scan counters, registered
// active-low syncs and a blanked, registered colour output.
module vga_sync_gen #(
  parameter int HD = 640,
  parameter int HF = 16,
  parameter int HR = 96,
  parameter int HB = 48,
  parameter int VD = 480,
  parameter int VF = 10,
  parameter int VR = 2,
  parameter int VB = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] rgb_in,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic       frame_tick,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [2:0] rgb
);

  localparam logic [9:0] H_MAX     = 10'(HD + HF + HR + HB - 1);
  localparam logic [9:0] V_MAX     = 10'(VD + VF + VR + VB - 1);
  localparam logic [9:0] H_VIS     = 10'(HD);
  localparam logic [9:0] V_VIS     = 10'(VD);
  localparam logic [9:0] H_SYNC_LO = 10'(HD + HF);
  localparam logic [9:0] H_SYNC_HI = 10'(HD + HF + HR - 1);
  localparam logic [9:0] V_SYNC_LO = 10'(VD + VF);
  localparam logic [9:0] V_SYNC_HI = 10'(VD + VF + VR - 1);

  logic [1:0] div;
  logic [9:0] h_cnt, v_cnt;
  logic [9:0] h_nxt, v_nxt;
  logic       h_end, v_end;

  assign p_tick     = (div == 2'd3);
  assign h_end      = (h_cnt == H_MAX);
  assign v_end      = (v_cnt == V_MAX);
  assign video_on   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign frame_tick = p_tick && h_end && v_end;
  assign pix_x      = h_cnt;
  assign pix_y      = v_cnt;

  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (p_tick) begin
      h_nxt = h_end ? 10'd0 : h_cnt + 10'd1;
      if (h_end) begin
        v_nxt = v_end ? 10'd0 : v_cnt + 10'd1;
      end
    end
  end

  // Syncs are decoded from the next-state counters so they switch on the
  // same edge as pix_x/pix_y instead of one clk later.
  always_ff @(posedge clk) begin
    if (reset) begin
      div   <= 2'd0;
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      rgb   <= 3'b000;
    end else begin
      div   <= div + 2'd1;
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      hsync <= ~((h_nxt >= H_SYNC_LO) && (h_nxt <= H_SYNC_HI));
      vsync <= ~((v_nxt >= V_SYNC_LO) && (v_nxt <= V_SYNC_HI));
      if (p_tick) begin
        rgb <= video_on ? rgb_in : 3'b000;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default-timing and shrunken-timing instances, each
// checked every clk against an arithmetic model derived from clocks since reset.
module tb_vga_sync_gen;

  logic       clk = 1'b0;
  logic [1:0] rst = 2'b11;
  logic [2:0] rgbIn [2] = '{3'b000, 3'b000};
  logic [1:0] hs, vs, von, pt, ft;
  logic [9:0] px [2];
  logic [9:0] py [2];
  logic [2:0] rgbOut [2];

  int cHD [2] = '{640, 8};
  int cHF [2] = '{16, 2};
  int cHR [2] = '{96, 2};
  int cHB [2] = '{48, 2};
  int cVD [2] = '{480, 4};
  int cVF [2] = '{10, 1};
  int cVR [2] = '{2, 1};
  int cVB [2] = '{33, 1};

  int         k [2] = '{0, 0};
  bit         valid [2] = '{1'b0, 1'b0};
  bit         forceWhite [2] = '{1'b0, 1'b0};
  logic [2:0] expRgb [2] = '{3'b000, 3'b000};
  logic [2:0] pendRgb [2] = '{3'b000, 3'b000};
  bit         pendStrobe [2] = '{1'b0, 1'b0};

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  vga_sync_gen dutDef (
    .clk(clk), .reset(rst[0]), .rgb_in(rgbIn[0]),
    .hsync(hs[0]), .vsync(vs[0]), .video_on(von[0]), .p_tick(pt[0]),
    .frame_tick(ft[0]), .pix_x(px[0]), .pix_y(py[0]), .rgb(rgbOut[0])
  );

  vga_sync_gen #(
    .HD(8), .HF(2), .HR(2), .HB(2), .VD(4), .VF(1), .VR(1), .VB(1)
  ) dutSmall (
    .clk(clk), .reset(rst[1]), .rgb_in(rgbIn[1]),
    .hsync(hs[1]), .vsync(vs[1]), .video_on(von[1]), .p_tick(pt[1]),
    .frame_tick(ft[1]), .pix_x(px[1]), .pix_y(py[1]), .rgb(rgbOut[1])
  );

  // Expected outputs as a function of the clk count since the last reset edge:
  // every 4th clk is a pixel, pixels walk a raster of (line length x frame height).
  function automatic logic [27:0] modelOut(input int i, input int kk, input logic [2:0] er);
    int ht, vt, p, x, y;
    logic hsE, vsE, vonE, ptE, ftE;
    ht   = cHD[i] + cHF[i] + cHR[i] + cHB[i];
    vt   = cVD[i] + cVF[i] + cVR[i] + cVB[i];
    p    = (kk / 4) % (ht * vt);
    x    = p % ht;
    y    = p / ht;
    hsE  = !((x >= cHD[i] + cHF[i]) && (x < cHD[i] + cHF[i] + cHR[i]));
    vsE  = !((y >= cVD[i] + cVF[i]) && (y < cVD[i] + cVF[i] + cVR[i]));
    vonE = (x < cHD[i]) && (y < cVD[i]);
    ptE  = (kk % 4) == 3;
    ftE  = ptE && (x == ht - 1) && (y == vt - 1);
    return {hsE, vsE, vonE, ptE, ftE, 10'(x), 10'(y), er};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      if (mismatched <= 40) $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] which, input int cycles);
    rst = rst | which;
    repeat (cycles) @(negedge clk);
    rst = rst & ~which;
  endtask

  task automatic waitPix(input int i, input int x, input int y);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (px[i] == 10'(x) && py[i] == 10'(y)) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput($sformatf("reach cfg%0d (%0d,%0d)", i, x, y), 32'(ok), 32'd1);
  endtask

  task automatic checkResetState(input int i, input string tag);
    checkOutput({tag, " pix_x"}, 32'(px[i]), 32'd0);
    checkOutput({tag, " pix_y"}, 32'(py[i]), 32'd0);
    checkOutput({tag, " rgb"}, 32'(rgbOut[i]), 32'd0);
    checkOutput({tag, " hsync"}, 32'(hs[i]), 32'd1);
    checkOutput({tag, " vsync"}, 32'(vs[i]), 32'd1);
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        k[i]      = 0;
        expRgb[i] = 3'b000;
        valid[i]  = 1'b1;
      end else if (valid[i]) begin
        k[i] = k[i] + 1;
        if (pendStrobe[i]) expRgb[i] = pendRgb[i];
      end
    end
  end

  // Per-clk compare, then pick the next random colour and note what the DUT
  // must latch if this clk is a pixel tick.
  always @(negedge clk) begin
    logic [27:0] got, want;
    logic [2:0]  newRgb;
    for (int i = 0; i < 2; i++) begin
      if (valid[i]) begin
        got  = {hs[i], vs[i], von[i], pt[i], ft[i], px[i], py[i], rgbOut[i]};
        want = modelOut(i, k[i], expRgb[i]);
        checkOutput($sformatf("cfg%0d clk%0d outputs", i, k[i]), 32'(got), 32'(want));
        newRgb        = forceWhite[i] ? 3'b111 : 3'($urandom_range(7, 0));
        rgbIn[i]      = newRgb;
        pendStrobe[i] = want[24];
        pendRgb[i]    = want[25] ? newRgb : 3'b000;
      end
    end
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hsLow, ptCnt, ftCnt, line0Cnt;
    bit done;
    logic [7:0] vsMask;

    applyStimulus(2'b11, 3);
    checkResetState(0, "reset");
    checkOutput("reset video_on", 32'(von[0]), 32'd1);
    checkOutput("reset frame_tick", 32'(ft[0]), 32'd0);
    for (int n = 1; n <= 12; n++) begin
      if (n > 1) @(negedge clk);
      checkOutput($sformatf("p_tick clk%0d", n), 32'(pt[0]), 32'(n % 4 == 0));
    end

    hsLow = 0;
    done  = 1'b0;
    for (int c = 0; c < 40000 && !done; c++) begin
      @(negedge clk);
      if (py[0] >= 10'd9) forceWhite[0] = 1'b1;
      if (pt[0] && py[0] == 10'd10 && !hs[0]) hsLow++;
      if (pt[0] && px[0] == 10'd799 && py[0] == 10'd10) done = 1'b1;
    end
    checkOutput("reach (799,10)", 32'(done), 32'd1);
    checkOutput("hsync low p_ticks line10", 32'(hsLow), 32'd96);
    @(negedge clk);
    checkOutput("line wrap pix_x", 32'(px[0]), 32'd0);
    checkOutput("line wrap pix_y", 32'(py[0]), 32'd11);
    checkOutput("line wrap rgb blank", 32'(rgbOut[0]), 32'd0);

    waitPix(0, 1, 11);
    checkOutput("rgb visible x1", 32'(rgbOut[0]), 32'd7);
    waitPix(0, 640, 11);
    checkOutput("rgb lag x640", 32'(rgbOut[0]), 32'd7);
    waitPix(0, 641, 11);
    checkOutput("rgb blank x641", 32'(rgbOut[0]), 32'd0);

    waitPix(0, 300, 12);
    applyStimulus(2'b01, 1);
    checkResetState(0, "midreset def");
    forceWhite[0] = 1'b0;

    done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      if (ft[1]) done = 1'b1;
    end
    checkOutput("small frame_tick seen", 32'(done), 32'd1);
    checkOutput("frame_tick pix_x", 32'(px[1]), 32'd13);
    checkOutput("frame_tick pix_y", 32'(py[1]), 32'd6);
    @(negedge clk);
    checkOutput("frame wrap pix_x", 32'(px[1]), 32'd0);
    checkOutput("frame wrap pix_y", 32'(py[1]), 32'd0);
    checkOutput("frame_tick one clk", 32'(ft[1]), 32'd0);

    ptCnt = 0; ftCnt = 0; line0Cnt = 0; hsLow = 0; vsMask = 8'h00;
    done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      if (pt[1]) begin
        ptCnt++;
        if (!vs[1] && py[1] < 10'd8) vsMask[py[1][2:0]] = 1'b1;
        if (py[1] == 10'd0) line0Cnt++;
        if (py[1] == 10'd0 && !hs[1]) hsLow++;
      end
      if (ft[1]) begin
        ftCnt++;
        done = 1'b1;
      end
    end
    checkOutput("small frame p_ticks", 32'(ptCnt), 32'd98);
    checkOutput("small frame_tick count", 32'(ftCnt), 32'd1);
    checkOutput("small line p_ticks", 32'(line0Cnt), 32'd14);
    checkOutput("small hsync low p_ticks", 32'(hsLow), 32'd2);
    checkOutput("small vsync low lines", 32'(vsMask), 32'h20);

    waitPix(1, 5, 3);
    applyStimulus(2'b10, 1);
    checkResetState(1, "midreset small");

    repeat (3000) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
